// File: rtl/rc4_avalon_master_if.sv
// Avalon-MM command/response bundle between rc4_avalon_master and the RC4 core slave port.
interface rc4_avalon_master_if;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/rc4_avalon_master.sv
// RC4 core driver: reset core, load key, poll ready, stream keystream bytes; 4 cycles/byte best case,
// every stage stalls on waitrequest / key_valid / ks_ready. Optional poll timeout: RC4_POLL_TIMEOUT_EN.
module rc4_avalon_master #(
  parameter int KEY_LEN      = 16,
  parameter int READ_LATENCY = 1,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                ks_count,
  input  logic                       stop,
  input  logic [7:0]                 key_data,
  input  logic                       key_valid,
  output logic                       key_ready,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  rc4_avalon_master_if.master        avm
);
  typedef enum logic [3:0] {
    IDLE, RST_WR, KEY_WAIT, KEY_WR, POLL_RD, POLL_WAIT,
    KS_RD, KS_WAIT, KS_OUT, ADV_WR, DONE
  } state_t;

  localparam logic [7:0] KEY_LAST = 8'(KEY_LEN - 1);
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [7:0]  key_idx_q, key_idx_d, key_byte_q, key_byte_d, ks_data_q, ks_data_d;
  logic [15:0] ks_cnt_q, ks_cnt_d, ks_tgt_q, ks_tgt_d;
  logic [2:0]  lat_q, lat_d;
  logic        stop_seen_q, stop_seen_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        key_ready_q, key_ready_d, ks_valid_q, ks_valid_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        accept, data_vld, core_rdy;
  logic        unused_rd;

`ifdef RC4_POLL_TIMEOUT_EN
  localparam logic [15:0] POLL_LAST = 16'(POLL_TIMEOUT - 1);
  logic [15:0] poll_q, poll_d;
  logic        err_q, err_d;
  assign err = err_q;
`else
  localparam int unused_poll_timeout = POLL_TIMEOUT;
  assign err = 1'b0;
`endif

  assign accept    = ~avm.avm_waitrequest;
  assign data_vld  = (lat_q == LAT_LAST);
  assign core_rdy  = avm.avm_readdata[24];
  assign unused_rd = ^{avm.avm_readdata[31:25], avm.avm_readdata[23:8]};

  always_comb begin
    state_d     = state_q;
    key_idx_d   = key_idx_q;
    key_byte_d  = key_byte_q;
    ks_data_d   = ks_data_q;
    ks_cnt_d    = ks_cnt_q;
    ks_tgt_d    = ks_tgt_q;
    lat_d       = lat_q;
    // stop is remembered from anywhere in a session and consumed at the next byte handshake
    stop_seen_d = stop_seen_q | (stop && state_q != IDLE);
`ifdef RC4_POLL_TIMEOUT_EN
    poll_d      = poll_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d     = RST_WR;
        ks_tgt_d    = ks_count;
        ks_cnt_d    = '0;
        key_idx_d   = '0;
        stop_seen_d = 1'b0;
`ifdef RC4_POLL_TIMEOUT_EN
        err_d       = 1'b0;
`endif
      end
      RST_WR: if (accept) state_d = KEY_WAIT;
      KEY_WAIT: if (key_valid) begin
        key_byte_d = key_data;
        state_d    = KEY_WR;
      end
      KEY_WR: if (accept) begin
        if (key_idx_q == KEY_LAST) begin
          key_idx_d = '0;
          state_d   = POLL_RD;
`ifdef RC4_POLL_TIMEOUT_EN
          poll_d    = '0;
`endif
        end else begin
          key_idx_d = key_idx_q + 8'd1;
          state_d   = KEY_WAIT;
        end
      end
      POLL_RD, KS_RD: if (accept) begin
        lat_d   = '0;
        state_d = (state_q == POLL_RD) ? POLL_WAIT : KS_WAIT;
      end
      POLL_WAIT: if (data_vld) begin
        if (core_rdy) state_d = KS_RD;
`ifdef RC4_POLL_TIMEOUT_EN
        else if (poll_q == POLL_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          poll_d  = poll_q + 16'd1;
          state_d = POLL_RD;
        end
`else
        else state_d = POLL_RD;
`endif
      end else lat_d = lat_q + 3'd1;
      KS_WAIT: if (data_vld) begin
        ks_data_d = avm.avm_readdata[7:0];
        state_d   = KS_OUT;
      end else lat_d = lat_q + 3'd1;
      KS_OUT: if (ks_ready) begin
        ks_cnt_d    = ks_cnt_q + 16'd1;
        stop_seen_d = 1'b0;
        if ((ks_tgt_q != 16'd0 && ks_cnt_d == ks_tgt_q) || stop_seen_q || stop) state_d = DONE;
        else state_d = ADV_WR;
      end
      ADV_WR: if (accept) state_d = KS_RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with state_q.
    rd_d = state_d inside {POLL_RD, KS_RD};
    wr_d = state_d inside {RST_WR, KEY_WR, ADV_WR};
    case (state_d)
      RST_WR:         begin be_d = 4'b1000; wd_d = 32'h0200_0000;                end
      KEY_WR:         begin be_d = 4'b1001; wd_d = {8'h01, 16'h0000, key_byte_d}; end
      ADV_WR:         begin be_d = 4'b1000; wd_d = 32'h0100_0000;                end
      POLL_RD, KS_RD: begin be_d = 4'b1111; wd_d = 32'h0000_0000;                end
      default:        begin be_d = 4'b0000; wd_d = 32'h0000_0000;                end
    endcase
    key_ready_d = (state_d == KEY_WAIT);
    ks_valid_d  = (state_d == KS_OUT);
    busy_d      = !(state_d inside {IDLE, DONE});
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      key_idx_q   <= '0;
      key_byte_q  <= '0;
      ks_data_q   <= '0;
      ks_cnt_q    <= '0;
      ks_tgt_q    <= '0;
      lat_q       <= '0;
      stop_seen_q <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      be_q        <= '0;
      wd_q        <= '0;
      key_ready_q <= 1'b0;
      ks_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RC4_POLL_TIMEOUT_EN
      poll_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_idx_q   <= key_idx_d;
      key_byte_q  <= key_byte_d;
      ks_data_q   <= ks_data_d;
      ks_cnt_q    <= ks_cnt_d;
      ks_tgt_q    <= ks_tgt_d;
      lat_q       <= lat_d;
      stop_seen_q <= stop_seen_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      wd_q        <= wd_d;
      key_ready_q <= key_ready_d;
      ks_valid_q  <= ks_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RC4_POLL_TIMEOUT_EN
      poll_q      <= poll_d;
      err_q       <= err_d;
`endif
    end
  end

  assign avm.avm_chipselect = rd_q | wr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wd_q;
  assign key_ready          = key_ready_q;
  assign ks_data            = ks_data_q;
  assign ks_valid           = ks_valid_q;
  assign busy               = busy_q;
  assign done               = done_q;
endmodule

// File: tb/tb_rc4_avalon_master.sv
// Bench for rc4_avalon_master: scripted RC4 slave with stalls, random key/keystream traffic;
// accepted bus commands and emitted bytes are compared with a transaction-level expectation.
module tb_rc4_avalon_master;
  localparam int KEY_LEN = 3;

  logic        clk = 1'b0;
  logic        reset, start, stop, key_valid, key_ready, ks_valid, ks_ready, busy, done, err;
  logic [15:0] ks_count;
  logic [7:0]  key_data, ks_data;

  rc4_avalon_master_if bus ();

  rc4_avalon_master #(.KEY_LEN(KEY_LEN), .READ_LATENCY(1), .POLL_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ks_count(ks_count), .stop(stop),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .busy(busy), .done(done), .err(err), .avm(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave-side state
  int          stall_max = 0;
  bit          stall_rand = 1'b0;
  int          polls_needed = 0;
  int          ks_idx = 0, reads_seen = 0, stall_left = 0;
  logic [7:0]  ks_bytes [64];
  logic [7:0]  t1_bytes [64];
  logic [7:0]  key_bytes [KEY_LEN];
  logic [37:0] log_q [$];
  logic [7:0]  got_q [$];
  int          got_cyc [$];
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] cmd(input logic rd, input logic wr, input logic [3:0] be,
                                      input logic [31:0] wd);
    return {rd, wr, be, wd};
  endfunction

  localparam logic [37:0] C_RST = {1'b0, 1'b1, 4'b1000, 32'h0200_0000};
  localparam logic [37:0] C_ADV = {1'b0, 1'b1, 4'b1000, 32'h0100_0000};
  localparam logic [37:0] C_RD  = {1'b1, 1'b0, 4'b1111, 32'h0000_0000};

  // RC4 slave: stalls each command, answers reads one cycle after acceptance
  initial begin : slave
    bit          in_cmd = 1'b0, rd_pend = 1'b0;
    logic [37:0] cur, held;
    logic [31:0] resp;
    held = '0; resp = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_cmd = 1'b0; rd_pend = 1'b0; bus.avm_waitrequest = 1'b0;
      end else begin
        bus.avm_readdata = rd_pend ? resp : $urandom;
        rd_pend = 1'b0;
        chk("rd_and_wr", 64'(bus.avm_read & bus.avm_write), 64'd0);
        if (bus.avm_read | bus.avm_write) begin
          cur = cmd(bus.avm_read, bus.avm_write, bus.avm_byteenable, bus.avm_writedata);
          chk("chipselect", 64'(bus.avm_chipselect), 64'd1);
          if (in_cmd) chk("cmd_held", 64'(cur), 64'(held));
          else begin
            in_cmd = 1'b1; held = cur;
            stall_left = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
          end
          if (stall_left > 0) begin
            bus.avm_waitrequest = 1'b1; stall_left--;
          end else begin
            bus.avm_waitrequest = 1'b0; in_cmd = 1'b0;
            log_q.push_back(cur);
            if (cur == C_RD) begin
              resp = {7'd0, 1'(reads_seen >= polls_needed), 16'd0, ks_bytes[ks_idx & 63]};
              reads_seen++; rd_pend = 1'b1;
            end else if (cur == C_RST) begin
              ks_idx = 0; reads_seen = 0;
            end else if (cur == C_ADV) ks_idx++;
          end
        end else begin
          bus.avm_waitrequest = 1'b0; in_cmd = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  task automatic feed_keys(input bit rand_gap, input bit stop_in_load);
    int i = 0;
    bit pend = 1'b0;
    for (int t = 0; t < 2000 && i < KEY_LEN; t++) begin
      @(negedge clk);
      if (stop_in_load) begin stop = pend; pend = 1'b0; end
      key_valid = rand_gap ? 1'($urandom_range(0, 1)) : 1'b1;
      key_data  = key_valid ? key_bytes[i] : 8'($urandom);
      if (key_valid && key_ready) begin
        i++;
        if (stop_in_load && i == 1) pend = 1'b1;
      end
    end
    chk("keys_fed", 64'(i), 64'(KEY_LEN));
    @(negedge clk);
    key_valid = 1'b0;
    if (stop_in_load) stop = 1'b0;
  endtask

  task automatic consume(input bit rand_ready, input int hold_first, input int stop_after,
                         input bit busy_start);
    int hold = 0;
    bit stop_next = 1'b0, sent = 1'b0, seen_done = 1'b0;
    for (int t = 0; t < 4000 && !seen_done; t++) begin
      @(negedge clk);
      if (stop_after > 0) begin stop = stop_next; stop_next = 1'b0; end
      if (busy_start) begin
        start = 1'b0;
        if (!sent && got_q.size() == 2) begin start = 1'b1; ks_count = 16'd1; sent = 1'b1; end
      end
      if (done) seen_done = 1'b1;
      else if ((ks_valid || hold > 0) && got_q.size() == 0 && hold < hold_first) begin
        ks_ready = 1'b0; hold++;
        chk("hold_valid", 64'(ks_valid), 64'd1);
        chk("hold_data", 64'(ks_data), 64'(ks_bytes[0]));
        chk("hold_bus_idle", 64'(bus.avm_read | bus.avm_write), 64'd0);
      end else begin
        ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ks_valid && ks_ready) begin
          got_q.push_back(ks_data);
          got_cyc.push_back(cyc);
          if (got_q.size() == stop_after) stop_next = 1'b1;
        end
      end
    end
    chk("done_seen", 64'(seen_done), 64'd1);
    ks_ready = 1'b0;
    if (busy_start) start = 1'b0;
    if (stop_after > 0) stop = 1'b0;
  endtask

  // One full session; expectation is built from the command protocol, not from the DUT.
  task automatic session(input logic [15:0] kc, input int n_exp, input int polls,
                         input bit timeout_exp, input bit rand_flow, input int hold_first,
                         input int stop_after, input bit busy_start, input bit stop_in_load,
                         input bit check_tput);
    logic [37:0] exp_q [$];
    int n_rd;
    polls_needed = polls;
    log_q.delete(); got_q.delete(); got_cyc.delete();
    if (hold_first > 0) ks_bytes[0] = 8'hA5;
    exp_q.push_back(C_RST);
    for (int k = 0; k < KEY_LEN; k++) exp_q.push_back(cmd(1'b0, 1'b1, 4'b1001, {8'h01, 16'h0, key_bytes[k]}));
    n_rd = timeout_exp ? 4 : polls + 1;
    for (int p = 0; p < n_rd; p++) exp_q.push_back(C_RD);
    if (!timeout_exp)
      for (int b = 0; b < n_exp; b++) begin
        if (b > 0) exp_q.push_back(C_ADV);
        exp_q.push_back(C_RD);
      end
    @(negedge clk);
    start = 1'b1; ks_count = kc;
    @(negedge clk);
    start = 1'b0; ks_count = 16'($urandom);
    done_cnt = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_after_start", 64'(err), 64'd0);
    fork
      feed_keys(rand_flow, stop_in_load);
      consume(rand_flow, hold_first, stop_after, busy_start);
    join
    repeat (4) @(negedge clk);
    chk("log_size", 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("log[%0d]", i), 64'(log_q[i]), 64'(exp_q[i]));
    chk("byte_count", 64'(got_q.size()), 64'(n_exp));
    for (int i = 0; i < got_q.size() && i < n_exp; i++)
      chk($sformatf("ks_byte[%0d]", i), 64'(got_q[i]), 64'(ks_bytes[i]));
    if (check_tput && got_cyc.size() >= 2)
      chk("byte_interval", 64'(got_cyc[1] - got_cyc[0]), 64'd4);
    chk("done_cycles", 64'(done_cnt), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("err_end", 64'(err), 64'(timeout_exp));
  endtask

  task automatic rand_ks();
    for (int i = 0; i < 64; i++) ks_bytes[i] = 8'($urandom);
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; ks_count = '0; stop = 1'b0;
    key_data = '0; key_valid = 1'b0; ks_ready = 1'b0;
    rand_ks();
    repeat (3) @(negedge clk);
    chk("rst_key_ready", 64'(key_ready), 64'd0);
    chk("rst_ks_valid", 64'(ks_valid), 64'd0);
    chk("rst_ks_data", 64'(ks_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cs", 64'(bus.avm_chipselect), 64'd0);
    chk("rst_read", 64'(bus.avm_read), 64'd0);
    chk("rst_write", 64'(bus.avm_write), 64'd0);
    chk("rst_be", 64'(bus.avm_byteenable), 64'd0);
    chk("rst_wd", 64'(bus.avm_writedata), 64'd0);
    reset = 1'b0;

    // key 01 02 03, two bytes, ready after two polls, full speed
    key_bytes[0] = 8'h01; key_bytes[1] = 8'h02; key_bytes[2] = 8'h03;
    t1_bytes = ks_bytes;
    session(16'd2, 2, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // first byte A5 held 10 cycles by ks_ready=0
    rand_ks();
    session(16'd3, 3, 1, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0);

    // every command stalled 3 cycles, same stream as the first session
    ks_bytes = t1_bytes; stall_max = 3;
    session(16'd2, 2, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    stall_max = 0;

    // unbounded, stop after the 5th handshake, stray start while busy
    rand_ks();
    session(16'd0, 6, 0, 1'b0, 1'b0, 0, 5, 1'b1, 1'b0, 1'b0);

    // stop during key load ends the session at the first handshake
    rand_ks();
    session(16'd0, 1, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // stop while idle is ignored
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    rand_ks();
    session(16'd3, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // reset while a key write is stalled
    stall_max = 3;
    @(negedge clk); start = 1'b1; ks_count = 16'd4;
    @(negedge clk); start = 1'b0; key_valid = 1'b1; key_data = 8'h3C;
    done_cnt = 0;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (bus.avm_write && bus.avm_byteenable == 4'b1001) found = 1'b1;
    end
    chk("key_wr_reached", 64'(found), 64'd1);
    chk("key_wr_wd", 64'(bus.avm_writedata), 64'h0100_003C);
    reset = 1'b1; key_valid = 1'b0;
    @(negedge clk);
    chk("abort_write", 64'(bus.avm_write), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_key_ready", 64'(key_ready), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    stall_max = 0;

`ifdef RC4_POLL_TIMEOUT_EN
    // core never ready: four polls, then err and done; next start clears err
    rand_ks();
    session(16'd2, 0, 1000, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    rand_ks();
    session(16'd2, 2, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
`endif

    // randomized sessions: random key, polls, length, stalls and flow control
    stall_rand = 1'b1; stall_max = 2;
    for (int s = 0; s < 6; s++) begin
      int kc;
      for (int k = 0; k < KEY_LEN; k++) key_bytes[k] = 8'($urandom);
      rand_ks();
      kc = int'($urandom_range(1, 6));
      session(16'(kc), kc, int'($urandom_range(0, 3)), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
